imu_burst_reader: RTL
=====================

IMU_BURST_READER -- requirements
Module: imu_burst_reader

Interface
REQ-001 Parameter DEV_ADDR, 7'h68, 7-bit I2C address of the IMU.
REQ-002 Parameter PWR_REG, 8'h6B, IMU wake register.
REQ-003 Parameter PWR_VAL, 8'h00, value written to PWR_REG during init.
REQ-004 Parameter DATA_REG, 8'h3B, first accelerometer register of the burst.
REQ-005 Parameter TIMEOUT, 16'd50000, maximum number of clocks to wait for i_cmd_done.
REQ-006 Port i_clk, input, 1, sole clock.
REQ-007 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port i_sample, input, 1, single-cycle request for one accelerometer sample.
REQ-009 Port o_cmd, output, 3, command to the I2C master (1 START, 2 WRITE, 4 READ_ACK, 5 READ_NACK, 6 STOP).
REQ-010 Port o_tx_data, output, 8, byte sent with START/WRITE.
REQ-011 Port o_cmd_valid, output, 1, single-cycle command strobe.
REQ-012 Port i_rx_data, input, 8, byte returned by the master.
REQ-013 Port i_cmd_done, input, 1, single-cycle completion pulse from the master.
REQ-014 Port i_cmd_error, input, 1, NACK or arbitration loss, valid with i_cmd_done.
REQ-015 Port o_accel_x / o_accel_y / o_accel_z, output, 16 each, signed samples.
REQ-016 Port o_valid, output, 1, one-cycle pulse when new samples are loaded.
REQ-017 Port o_init_done, output, 1, IMU wake sequence completed.
REQ-018 Port o_busy, output, 1, high whenever the state is not IDLE.
REQ-019 Port o_error, output, 1, one-cycle pulse on an aborted transaction.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, ABORT_ISSUE and ABORT_WAIT, plus a step index selecting the command.
REQ-021 The init sequence SHALL be: START(DEV_ADDR,0), WRITE PWR_REG, WRITE PWR_VAL, STOP.
REQ-022 The read sequence SHALL be: START(DEV_ADDR,0), WRITE DATA_REG, START(DEV_ADDR,1), READ_ACK x5, READ_NACK, STOP.
REQ-023 On leaving reset the block SHALL start the init sequence automatically, with o_cmd_valid asserted on the first clock after reset deassertion.
REQ-024 An i_sample in IDLE with o_init_done=1 SHALL issue the read-sequence START on o_cmd_valid in the next cycle.
REQ-025 An i_sample in IDLE with o_init_done=0 SHALL rerun init and then the read sequence without a further request.
REQ-026 An i_sample while o_busy=1 SHALL set a single pending flag; the flag SHALL be serviced on return to IDLE, and extra requests SHALL be dropped.
REQ-027 ISSUE SHALL assert o_cmd_valid for exactly one cycle with o_cmd and o_tx_data held stable until i_cmd_done, then move to WAIT.
REQ-028 In WAIT, i_cmd_done SHALL advance the step and return to ISSUE in the next cycle, or to IDLE after the final STOP.
REQ-029 Bytes read SHALL be stored in shadow registers in order XH, XL, YH, YL, ZH, ZL; each axis SHALL be {H,L}.
REQ-030 o_accel_* SHALL be loaded from the shadows, with o_valid pulsed, in the cycle i_cmd_done of the read-sequence STOP is seen.
REQ-031 o_init_done SHALL set when i_cmd_done of the init STOP is seen.
REQ-032 i_cmd_error SHALL be honoured only on START/WRITE completions; on READ/STOP completions it SHALL be ignored.
REQ-033 An honoured error, or TIMEOUT clocks in WAIT without i_cmd_done, SHALL enter ABORT_ISSUE: issue STOP, wait for done or timeout, then pulse o_error and return to IDLE.
REQ-034 An abort during init SHALL leave o_init_done=0.
REQ-035 An abort SHALL leave o_accel_* unchanged, and o_valid SHALL not pulse.
REQ-036 A timeout in ABORT_WAIT SHALL still pulse o_error and return to IDLE.
REQ-037 The timeout counter SHALL clear on each o_cmd_valid and saturate rather than wrap.

Reset
REQ-038 Asynchronous assertion of i_rst_n=0 SHALL force IDLE, step 0, pending=0, o_cmd_valid=0, o_cmd=0, o_tx_data=0, o_accel_*=0, o_valid=0, o_init_done=0, o_busy=0, o_error=0, and clear the timeout counter, including mid-transaction.

Verification
REQ-039 Reset release with a responder that ACKs every command -> commands 1/8'hD0, 2/8'h6B, 2/8'h00, 6 in order, then o_init_done=1 and o_busy=0.
REQ-040 i_sample with responder bytes 12,34,FF,FE,80,00 -> o_valid pulse with x=16'h1234, y=16'hFFFE, z=16'h8000; the third command is 1/8'hD1.
REQ-041 NACK on the START of a read -> next command is STOP, then one o_error pulse, o_accel_* unchanged, and no o_valid.
REQ-042 Responder never asserts done -> after 50000 clocks a STOP is issued, and after a second timeout o_error pulses and the block returns to IDLE.
REQ-043 Three i_sample pulses during one burst -> exactly one additional burst follows.
REQ-044 i_rst_n asserted mid-burst -> all outputs are zero immediately, and the init sequence reruns after release.

Source files
------------

// File: rtl/imu_burst_reader.sv
// Wakes an I2C IMU after reset, then on request bursts six accelerometer bytes
// through a byte-level I2C master and presents them as signed X/Y/Z samples.
module imu_burst_reader #(
  parameter logic [6:0]  DEV_ADDR = 7'h68,
  parameter logic [7:0]  PWR_REG  = 8'h6B,
  parameter logic [7:0]  PWR_VAL  = 8'h00,
  parameter logic [7:0]  DATA_REG = 8'h3B,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sample,
  output logic [2:0]         o_cmd,
  output logic [7:0]         o_tx_data,
  output logic               o_cmd_valid,
  input  logic [7:0]         i_rx_data,
  input  logic               i_cmd_done,
  input  logic               i_cmd_error,
  output logic signed [15:0] o_accel_x,
  output logic signed [15:0] o_accel_y,
  output logic signed [15:0] o_accel_z,
  output logic               o_valid,
  output logic               o_init_done,
  output logic               o_busy,
  output logic               o_error
);

  localparam logic [2:0] CMD_START   = 3'd1;
  localparam logic [2:0] CMD_WRITE   = 3'd2;
  localparam logic [2:0] CMD_RD_ACK  = 3'd4;
  localparam logic [2:0] CMD_RD_NACK = 3'd5;
  localparam logic [2:0] CMD_STOP    = 3'd6;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT_ISSUE, ABORT_WAIT} state_t;

  state_t      state;
  logic [3:0]  step;
  logic        in_init;
  logic        read_after;
  logic        boot;
  logic        pending;
  logic [15:0] tcnt;
  logic [47:0] shadow;

  logic req, tmo, last_step, is_read_cmd, err_ok;

  assign req         = pending | i_sample | read_after;
  assign tmo         = (tcnt >= TIMEOUT - 16'd1);
  assign last_step   = in_init ? (step == 4'd3) : (step == 4'd9);
  assign is_read_cmd = (o_cmd == CMD_RD_ACK) || (o_cmd == CMD_RD_NACK);
  assign err_ok      = i_cmd_error && ((o_cmd == CMD_START) || (o_cmd == CMD_WRITE));

  // {command, byte} for each step of the init and read sequences
  function automatic logic [10:0] seq_cmd(input logic init_seq, input logic [3:0] idx);
    logic [10:0] c;
    c = {CMD_STOP, 8'h00};
    if (init_seq) begin
      case (idx)
        4'd0:    c = {CMD_START, DEV_ADDR, 1'b0};
        4'd1:    c = {CMD_WRITE, PWR_REG};
        4'd2:    c = {CMD_WRITE, PWR_VAL};
        default: c = {CMD_STOP, 8'h00};
      endcase
    end else begin
      case (idx)
        4'd0:                         c = {CMD_START, DEV_ADDR, 1'b0};
        4'd1:                         c = {CMD_WRITE, DATA_REG};
        4'd2:                         c = {CMD_START, DEV_ADDR, 1'b1};
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7: c = {CMD_RD_ACK, 8'h00};
        4'd8:                         c = {CMD_RD_NACK, 8'h00};
        default:                      c = {CMD_STOP, 8'h00};
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      step        <= 4'd0;
      in_init     <= 1'b0;
      read_after  <= 1'b0;
      boot        <= 1'b1;
      pending     <= 1'b0;
      tcnt        <= 16'd0;
      o_cmd       <= 3'd0;
      o_tx_data   <= 8'h00;
      o_cmd_valid <= 1'b0;
      o_accel_x   <= 16'sd0;
      o_accel_y   <= 16'sd0;
      o_accel_z   <= 16'sd0;
      o_valid     <= 1'b0;
      o_init_done <= 1'b0;
      o_busy      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_error     <= 1'b0;
      o_cmd_valid <= 1'b0;
      if (o_cmd_valid) tcnt <= 16'd0;
      else if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
      if (state != IDLE && i_sample) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (boot || (req && !o_init_done)) begin
            // a request arriving before the IMU is awake is folded into the init run
            boot                 <= 1'b0;
            in_init              <= 1'b1;
            read_after           <= req;
            pending              <= 1'b0;
            step                 <= 4'd0;
            {o_cmd, o_tx_data}   <= seq_cmd(1'b1, 4'd0);
            o_cmd_valid          <= 1'b1;
            o_busy               <= 1'b1;
            state                <= ISSUE;
          end else if (req) begin
            in_init              <= 1'b0;
            read_after           <= 1'b0;
            pending              <= 1'b0;
            step                 <= 4'd0;
            {o_cmd, o_tx_data}   <= seq_cmd(1'b0, 4'd0);
            o_cmd_valid          <= 1'b1;
            o_busy               <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (i_cmd_done) begin
            if (err_ok) begin
              {o_cmd, o_tx_data} <= {CMD_STOP, 8'h00};
              o_cmd_valid        <= 1'b1;
              state              <= ABORT_ISSUE;
            end else if (last_step) begin
              if (in_init) begin
                o_init_done <= 1'b1;
              end else begin
                o_accel_x <= $signed(shadow[47:32]);
                o_accel_y <= $signed(shadow[31:16]);
                o_accel_z <= $signed(shadow[15:0]);
                o_valid   <= 1'b1;
              end
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              step               <= step + 4'd1;
              {o_cmd, o_tx_data} <= seq_cmd(in_init, step + 4'd1);
              o_cmd_valid        <= 1'b1;
              state              <= ISSUE;
            end
          end else if (tmo) begin
            {o_cmd, o_tx_data} <= {CMD_STOP, 8'h00};
            o_cmd_valid        <= 1'b1;
            state              <= ABORT_ISSUE;
          end
        end
        ABORT_ISSUE: state <= ABORT_WAIT;
        ABORT_WAIT: begin
          if (i_cmd_done || tmo) begin
            o_error    <= 1'b1;
            read_after <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bytes shift in XH first, so after six reads the register holds {X, Y, Z}
  always_ff @(posedge i_clk) begin
    if (state == WAIT && i_cmd_done && is_read_cmd) shadow <= {shadow[39:0], i_rx_data};
  end

endmodule
